// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the control FSM and the multiply/divide unit.
// The control FSM is the master; the arithmetic unit is the slave.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit feeding HI/LO.
// State  | meaning
// IDLE   | waiting for start; hi/lo/div_zero hold last result
// MULT   | Booth iterations, then load product into hi/lo
// DIV    | restoring iterations on magnitudes, then load sign-fixed q/r
// FINISH | one-cycle done pulse
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int AW = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MULT   = 2'd1,
        S_DIV    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [AW-1:0]    r_acc;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div_zero;

    logic             w_cnt_last;
    logic             w_dz;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_a_ext;
    logic [WIDTH:0]   w_m_ext;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic [AW-1:0]    w_booth_nxt;
    logic [AW-1:0]    w_div_nxt;
    logic [WIDTH-1:0] w_q_mag;
    logic [WIDTH-1:0] w_r_mag;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;

    assign w_cnt_last = (r_cnt == CW'(WIDTH));
    // A zero divisor spends one DIV cycle so that done lands one edge after acceptance.
    assign w_dz       = (r_state == S_DIV) && (r_m == '0);
    assign w_abs_a    = bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign w_abs_b    = bus.b[WIDTH-1] ? -bus.b : bus.b;

    // Booth accumulator: {A, Q, q_-1}. The add is done one bit wider so that
    // subtracting the most negative multiplicand cannot overflow before the shift.
    assign w_a_ext = {r_acc[AW-1], r_acc[AW-1:WIDTH+1]};
    assign w_m_ext = {r_m[WIDTH-1], r_m};

    always_comb begin
        case (r_acc[1:0])
            2'b01:   w_sum = w_a_ext + w_m_ext;
            2'b10:   w_sum = w_a_ext - w_m_ext;
            default: w_sum = w_a_ext;
        endcase
    end

    assign w_booth_nxt = {w_sum, r_acc[WIDTH:1]};

    // Divide layout: remainder in [2W-1:W], quotient/dividend bits in [W-1:0].
    assign w_rem_sh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_m};
    assign w_div_nxt = w_diff[WIDTH]
                     ? {1'b0, w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                     : {1'b0, w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};

    assign w_q_mag = r_acc[WIDTH-1:0];
    assign w_r_mag = r_acc[2*WIDTH-1:WIDTH];
    assign w_quot  = r_neg_q ? -w_q_mag : w_q_mag;
    assign w_rem   = r_neg_r ? -w_r_mag : w_r_mag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = bus.op ? S_DIV : S_MULT;
                end
            end
            S_MULT: begin
                if (w_cnt_last) begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_DIV: begin
                if (w_dz || w_cnt_last) begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_m        <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_cnt      <= '0;
                        r_div_zero <= 1'b0;
                        if (bus.op) begin
                            r_m     <= w_abs_b;
                            r_acc   <= {{(WIDTH+1){1'b0}}, w_abs_a};
                            r_neg_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                            r_neg_r <= bus.a[WIDTH-1];
                        end else begin
                            r_m     <= bus.a;
                            r_acc   <= {{WIDTH{1'b0}}, bus.b, 1'b0};
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                        end
                    end
                end
                S_MULT: begin
                    if (w_cnt_last) begin
                        r_hi <= r_acc[AW-1:WIDTH+1];
                        r_lo <= r_acc[WIDTH:1];
                    end else begin
                        r_acc <= w_booth_nxt;
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DIV: begin
                    if (w_dz) begin
                        r_div_zero <= 1'b1;
                    end else if (w_cnt_last) begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end else begin
                        r_acc <= w_div_nxt;
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = (r_state == S_FINISH);
    assign bus.div_zero = r_div_zero;
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO/div_zero and done cycle,
// a negedge monitor pops and compares on every done and checks hi/lo hold in between.
module tb_mult_div_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;

    mult_div_unit_if #(.WIDTH(W)) bus ();

    mult_div_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [31:0] s_hi     = '0;
    logic [31:0] s_lo     = '0;
    logic [31:0] held_hi  = '0;
    logic [31:0] held_lo  = '0;
    logic        prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference: plain signed 64-bit arithmetic; SV / and % truncate toward zero.
    function automatic void model(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                                  output logic [31:0] hi_o, output logic [31:0] lo_o, output logic dz_o);
        longint sa;
        longint sbv;
        longint p;
        longint q;
        longint r;
        sa   = longint'($signed(a_i));
        sbv  = longint'($signed(b_i));
        dz_o = 1'b0;
        if (!op_i) begin
            p    = sa * sbv;
            hi_o = p[63:32];
            lo_o = p[31:0];
        end else if (b_i == 32'd0) begin
            dz_o = 1'b1;
            hi_o = s_hi;
            lo_o = s_lo;
        end else begin
            q    = sa / sbv;
            r    = sa % sbv;
            hi_o = r[31:0];
            lo_o = q[31:0];
        end
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic do_op(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i);
        logic [31:0] eh;
        logic [31:0] el;
        logic        edz;
        exp_t        e;
        bit          idle;
        @(negedge clk);
        model(op_i, a_i, b_i, eh, el, edz);
        e.hi  = eh;
        e.lo  = el;
        e.dz  = edz;
        e.cyc = cyc + (edz ? 2 : 34);
        sb.push_back(e);
        if (!edz) begin
            s_hi = eh;
            s_lo = el;
        end
        bus.start = 1'b1;
        bus.op    = op_i;
        bus.a     = a_i;
        bus.b     = b_i;
        @(posedge clk);
        #1;
        chk("busy_after_accept", {63'd0, bus.busy}, 64'd1);
        chk("dz_cleared_on_accept", {63'd0, bus.div_zero}, 64'd0);
        bus.start = 1'b0;
        bus.op    = 1'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
        idle = 1'b0;
        // Random start pulses while busy (including the done cycle) must be ignored.
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                idle      = 1'b1;
                bus.start = 1'b0;
                break;
            end
            bus.start = ($urandom_range(3) == 0);
            bus.op    = 1'($urandom);
            bus.a     = $urandom;
            bus.b     = $urandom;
        end
        if (!idle) begin
            checks++;
            failures++;
            bus.start = 1'b0;
            $display("FAIL busy_timeout actual=busy required=idle within 60 cycles");
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            held_hi   = '0;
            held_lo   = '0;
            prev_done = 1'b0;
        end else begin
            if (bus.done) begin
                if (prev_done) begin
                    checks++;
                    failures++;
                    $display("FAIL done_twice actual=2 cycles required=1 cycle");
                end
                chk("busy_with_done", {63'd0, bus.busy}, 64'd1);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                    chk("hi", {32'd0, bus.hi}, {32'd0, e.hi});
                    chk("lo", {32'd0, bus.lo}, {32'd0, e.lo});
                    chk("div_zero", {63'd0, bus.div_zero}, {63'd0, e.dz});
                    held_hi = e.hi;
                    held_lo = e.lo;
                end
            end else begin
                chk("hold_hi", {32'd0, bus.hi}, {32'd0, held_hi});
                chk("hold_lo", {32'd0, bus.lo}, {32'd0, held_lo});
            end
            prev_done = bus.done;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        chk("rst_div_zero", {63'd0, bus.div_zero}, 64'd0);
        chk("rst_hi", {32'd0, bus.hi}, 64'd0);
        chk("rst_lo", {32'd0, bus.lo}, 64'd0);
        rst = 1'b0;

        do_op(1'b0, 32'd7, 32'hFFFF_FFFD);
        do_op(1'b0, 32'h8000_0000, 32'h8000_0000);
        do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2);
        do_op(1'b1, 32'd7, 32'hFFFF_FFFE);
        do_op(1'b1, 32'h0000_0451, 32'h0000_0020);
        do_op(1'b1, 32'd5, 32'd0);
        chk("dz_held", {63'd0, bus.div_zero}, 64'd1);
        chk("dz_hi_kept", {32'd0, bus.hi}, 64'h11);
        chk("dz_lo_kept", {32'd0, bus.lo}, 64'h22);
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);

        for (int n = 0; n < 40; n++) begin
            do_op(1'($urandom), pick(), pick());
        end

        // Abort a multiply with reset mid-cycle; an ignored start arrives first.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.a     = 32'd3;
        bus.b     = 32'd4;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("busy_ignored_start", {63'd0, bus.busy}, 64'd1);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("async_rst_done", {63'd0, bus.done}, 64'd0);
        chk("async_rst_div_zero", {63'd0, bus.div_zero}, 64'd0);
        chk("async_rst_hi", {32'd0, bus.hi}, 64'd0);
        chk("async_rst_lo", {32'd0, bus.lo}, 64'd0);
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        s_hi = '0;
        s_lo = '0;
        do_op(1'b0, 32'd3, 32'd4);

        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain actual=%0d pending required=0 pending", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
